// File: rtl/vertex_transform_fx_if.sv
// Vertex transform stage bus.
// Upstream side : pos, yaw, pitch, roll, scale, offset, obj_done_in, valid_in -> ready_out
// Downstream side: valid_out, new_pos, obj_done_out -> ready_in
// master: producer/consumer environment around the stage; slave: the transform stage.
interface vertex_transform_fx_if #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned ANGLE_BITS = 5
);
   logic [3:0][WIDTH-1:0]  pos;
   logic [ANGLE_BITS-1:0]  yaw;
   logic [ANGLE_BITS-1:0]  pitch;
   logic [ANGLE_BITS-1:0]  roll;
   logic [WIDTH-1:0]       scale;
   logic [2:0][WIDTH-1:0]  offset;
   logic                   obj_done_in;
   logic                   valid_in;
   logic                   ready_out;
   logic                   valid_out;
   logic [3:0][WIDTH-1:0]  new_pos;
   logic                   obj_done_out;
   logic                   ready_in;

   modport master (
      output pos, yaw, pitch, roll, scale, offset, obj_done_in, valid_in, ready_in,
      input  ready_out, valid_out, new_pos, obj_done_out
   );

   modport slave (
      input  pos, yaw, pitch, roll, scale, offset, obj_done_in, valid_in, ready_in,
      output ready_out, valid_out, new_pos, obj_done_out
   );
endinterface

// File: rtl/vertex_transform_fx.sv
// Fixed-point vertex transform: yaw (about y), pitch (about x), roll (about z), uniform scale,
// then per-axis translation, all on one time-multiplexed multiplier. Fixed 16-edge latency.
// Ports:
//   clk_in   - system clock
//   rst_n_in - asynchronous active-low reset
//   bus      - vertex_transform_fx_if slave: vertex in (valid/ready), transformed vertex out
module vertex_transform_fx #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned FRAC       = 16,
   parameter int unsigned ANGLE_BITS = 5
) (
   input logic                  clk_in,
   input logic                  rst_n_in,
   vertex_transform_fx_if.slave bus
);

   localparam int ANGLES = 2 ** ANGLE_BITS;

   typedef logic signed [WIDTH-1:0]   word_t;
   typedef logic signed [WIDTH+1:0]   sum_t;
   typedef logic signed [2*WIDTH-1:0] wide_t;
   typedef logic signed [FRAC+1:0]    trig_t;

   typedef enum logic [2:0] {
      StIdle, StYaw, StPitch, StRoll, StScale, StXlate, StHold
   } state_e;

   // round(sin/cos(2*pi*k/ANGLES) * 2^FRAC), evaluated at elaboration
   function automatic trig_t lut_entry(input int k, input bit is_sin);
      real ang;
      real v;
      int  r;
      ang = 2.0 * 3.14159265358979323846 * $itor(k) / $itor(ANGLES);
      v   = (is_sin ? $sin(ang) : $cos(ang)) * $pow(2.0, $itor(FRAC));
      if (v >= 0.0) r = $rtoi(v + 0.5);
      else          r = -$rtoi(0.5 - v);
      return r[FRAC+1:0];
   endfunction

   function automatic word_t sat(input wide_t v);
      wide_t hi;
      wide_t lo;
      hi = wide_t'({1'b0, {(WIDTH-1){1'b1}}});
      lo = ~hi;
      if (v > hi)      return {1'b0, {(WIDTH-1){1'b1}}};
      else if (v < lo) return {1'b1, {(WIDTH-1){1'b0}}};
      else             return v[WIDTH-1:0];
   endfunction

   trig_t sin_lut [ANGLES];
   trig_t cos_lut [ANGLES];

   for (genvar k = 0; k < ANGLES; k++) begin : g_lut
      assign sin_lut[k] = lut_entry(k, 1'b1);
      assign cos_lut[k] = lut_entry(k, 1'b0);
   end

   state_e                state_q;
   logic [1:0]            step_q;
   word_t                 x_q, y_q, z_q, w_q, scale_q;
   word_t                 off_q [3];
   logic [ANGLE_BITS-1:0] yaw_q, pitch_q, roll_q;
   logic                  done_q;
   sum_t                  p0_q, p1_q, p2_q;
   logic                  valid_q;
   logic                  obj_done_q;
   logic [3:0][WIDTH-1:0] new_pos_q;

   logic [ANGLE_BITS-1:0] ang;
   word_t                 rot_a, rot_b, trig_c, trig_s, mul_a, mul_b;
   wide_t                 prod;
   sum_t                  prod_n, rot_diff, rot_sum;
   word_t                 rot_a_new, rot_b_new;
   sum_t                  xl_x, xl_y, xl_z;

   always_comb begin
      // Rotation operand pair (a, b) and the angle for the current rotation state
      ang   = yaw_q;
      rot_a = x_q;
      rot_b = z_q;
      case (state_q)
         StPitch: begin ang = pitch_q; rot_a = y_q; rot_b = z_q; end
         StRoll:  begin ang = roll_q;  rot_a = x_q; rot_b = y_q; end
         default: ;
      endcase
      trig_c = word_t'(cos_lut[ang]);
      trig_s = word_t'(sin_lut[ang]);

      mul_a = '0;
      mul_b = '0;
      if (state_q inside {StYaw, StPitch, StRoll}) begin
         // Product order per rotation: a*c, b*s, a*s, b*c
         case (step_q)
            2'd0:    begin mul_a = rot_a; mul_b = trig_c; end
            2'd1:    begin mul_a = rot_b; mul_b = trig_s; end
            2'd2:    begin mul_a = rot_a; mul_b = trig_s; end
            default: begin mul_a = rot_b; mul_b = trig_c; end
         endcase
      end else if (state_q == StScale) begin
         mul_b = scale_q;
         case (step_q)
            2'd0:    mul_a = x_q;
            2'd1:    mul_a = y_q;
            default: mul_a = z_q;
         endcase
      end

      // Full-precision product, floor-shifted back to FRAC fractional bits
      prod   = (wide_t'(mul_a) * wide_t'(mul_b)) >>> FRAC;
      // |trig| <= 1.0, so a rotation product always fits in WIDTH+2 bits
      prod_n = prod[WIDTH+1:0];

      rot_diff  = p0_q - p1_q;
      rot_sum   = p2_q + prod_n;
      rot_a_new = sat(wide_t'(rot_diff));
      rot_b_new = sat(wide_t'(rot_sum));

      xl_x = sum_t'(x_q) + sum_t'(off_q[0]);
      xl_y = sum_t'(y_q) + sum_t'(off_q[1]);
      xl_z = sum_t'(z_q) + sum_t'(off_q[2]);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q    <= StIdle;
         step_q     <= '0;
         x_q        <= '0;
         y_q        <= '0;
         z_q        <= '0;
         w_q        <= '0;
         scale_q    <= '0;
         off_q      <= '{default: '0};
         yaw_q      <= '0;
         pitch_q    <= '0;
         roll_q     <= '0;
         done_q     <= 1'b0;
         p0_q       <= '0;
         p1_q       <= '0;
         p2_q       <= '0;
         valid_q    <= 1'b0;
         obj_done_q <= 1'b0;
         new_pos_q  <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.valid_in) begin
                  x_q      <= bus.pos[0];
                  y_q      <= bus.pos[1];
                  z_q      <= bus.pos[2];
                  w_q      <= bus.pos[3];
                  scale_q  <= bus.scale;
                  off_q[0] <= bus.offset[0];
                  off_q[1] <= bus.offset[1];
                  off_q[2] <= bus.offset[2];
                  yaw_q    <= bus.yaw;
                  pitch_q  <= bus.pitch;
                  roll_q   <= bus.roll;
                  done_q   <= bus.obj_done_in;
                  step_q   <= '0;
                  state_q  <= StYaw;
               end
            end
            StYaw, StPitch, StRoll: begin
               // 2-bit step wraps to 0 after the fourth product, ready for the next stage
               step_q <= step_q + 2'd1;
               case (step_q)
                  2'd0: p0_q <= prod_n;
                  2'd1: p1_q <= prod_n;
                  2'd2: p2_q <= prod_n;
                  default: begin
                     case (state_q)
                        StYaw: begin
                           x_q     <= rot_a_new;
                           z_q     <= rot_b_new;
                           state_q <= StPitch;
                        end
                        StPitch: begin
                           y_q     <= rot_a_new;
                           z_q     <= rot_b_new;
                           state_q <= StRoll;
                        end
                        default: begin
                           x_q     <= rot_a_new;
                           y_q     <= rot_b_new;
                           state_q <= StScale;
                        end
                     endcase
                  end
               endcase
            end
            StScale: begin
               case (step_q)
                  2'd0: begin x_q <= sat(prod); step_q <= 2'd1; end
                  2'd1: begin y_q <= sat(prod); step_q <= 2'd2; end
                  default: begin
                     z_q     <= sat(prod);
                     step_q  <= '0;
                     state_q <= StXlate;
                  end
               endcase
            end
            StXlate: begin
               new_pos_q[0] <= sat(wide_t'(xl_x));
               new_pos_q[1] <= sat(wide_t'(xl_y));
               new_pos_q[2] <= sat(wide_t'(xl_z));
               new_pos_q[3] <= w_q;
               obj_done_q   <= done_q;
               valid_q      <= 1'b1;
               state_q      <= StHold;
            end
            StHold: begin
               if (bus.ready_in) begin
                  valid_q <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.ready_out    = (state_q == StIdle);
   assign bus.valid_out    = valid_q;
   assign bus.new_pos      = new_pos_q;
   assign bus.obj_done_out = obj_done_q;

endmodule

// File: tb/tb_vertex_transform_fx.sv
// Directed self-checking bench for vertex_transform_fx (WIDTH=32, FRAC=16, ANGLE_BITS=5).
module tb_vertex_transform_fx;
   localparam int unsigned WIDTH      = 32;
   localparam int unsigned FRAC       = 16;
   localparam int unsigned ANGLE_BITS = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   vertex_transform_fx_if #(.WIDTH(WIDTH), .ANGLE_BITS(ANGLE_BITS)) bus ();

   vertex_transform_fx #(
      .WIDTH      (WIDTH),
      .FRAC       (FRAC),
      .ANGLE_BITS (ANGLE_BITS)
   ) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_vtx(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                          input logic [31:0] w, input logic [4:0] yw, input logic [4:0] pt,
                          input logic [4:0] rl, input logic [31:0] sc, input logic [31:0] o0,
                          input logic [31:0] o1, input logic [31:0] o2, input logic done);
      bus.pos         = {w, z, y, x};
      bus.yaw         = yw;
      bus.pitch       = pt;
      bus.roll        = rl;
      bus.scale       = sc;
      bus.offset      = {o2, o1, o0};
      bus.obj_done_in = done;
   endtask

   // Edges from the accept edge until valid_out is seen high; -1 if it never rises
   task automatic wait_valid(output int lat);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (bus.valid_out === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic run_vtx(output int lat, input bit scramble);
      int n;
      bus.valid_in = 1'b1;
      n = 0;
      while (bus.ready_out !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      step();
      bus.valid_in = 1'b0;
      if (scramble) set_vtx('1, '1, '1, '1, 5'd3, 5'd7, 5'd11, 32'h7fff_ffff, '1, '1, '1, 1'b0);
      wait_valid(lat);
   endtask

   task automatic do_vtx(input string tag, input logic [127:0] exp_pos, input logic exp_done,
                         input bit scramble);
      int lat;
      run_vtx(lat, scramble);
      check({tag, " latency"}, lat, 16);
      check({tag, " new_pos"}, bus.new_pos, exp_pos);
      check({tag, " obj_done_out"}, bus.obj_done_out, exp_done);
      check({tag, " ready_out busy"}, bus.ready_out, 1'b0);
      step();
      check({tag, " valid_out drop"}, bus.valid_out, 1'b0);
   endtask

   localparam logic [127:0] ExpIdent = {32'h0000_1234, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
   localparam logic [127:0] ExpA     = {32'h0000_abcd, 32'h0006_0000, 32'h0005_0000, 32'h0004_0000};
   localparam logic [127:0] ExpB     = {32'h0000_bbbb, 32'h0000_0000, 32'h0000_0000, 32'h0007_0000};

   initial begin
      int lat;
      int seen;
      set_vtx('0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0);
      bus.valid_in = 1'b0;
      bus.ready_in = 1'b1;

      #12;
      check("reset valid_out", bus.valid_out, 1'b0);
      check("reset ready_out", bus.ready_out, 1'b1);
      check("reset new_pos", bus.new_pos, '0);
      check("reset obj_done_out", bus.obj_done_out, 1'b0);
      step();
      rst_n = 1'b1;
      step();

      // Identity; inputs scrambled right after accept must not matter
      set_vtx(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0000_1234, 5'd0, 5'd0, 5'd0,
              32'h0001_0000, '0, '0, '0, 1'b1);
      do_vtx("identity", ExpIdent, 1'b1, 1'b1);

      set_vtx(32'h0001_0000, '0, '0, 32'hcafe_f00d, 5'd8, 5'd0, 5'd0, 32'h0001_0000, '0, '0, '0,
              1'b0);
      do_vtx("yaw90", {32'hcafe_f00d, 32'h0001_0000, 32'h0, 32'h0}, 1'b0, 1'b0);

      set_vtx(32'h0001_0000, '0, '0, '0, 5'd0, 5'd0, 5'd8, 32'h0001_0000, '0, '0, '0, 1'b0);
      do_vtx("roll90", {32'h0, 32'h0, 32'h0001_0000, 32'h0}, 1'b0, 1'b0);

      set_vtx('0, 32'h0001_0000, '0, '0, 5'd0, 5'd8, 5'd0, 32'h0001_0000, '0, '0, '0, 1'b0);
      do_vtx("pitch90", {32'h0, 32'h0001_0000, 32'h0, 32'h0}, 1'b0, 1'b0);

      set_vtx(32'h0001_0000, '0, 32'h0002_0000, '0, 5'd16, 5'd0, 5'd0, 32'h0001_0000, '0, '0, '0,
              1'b0);
      do_vtx("yaw180", {32'h0, 32'hfffe_0000, 32'h0, 32'hffff_0000}, 1'b0, 1'b0);

      set_vtx(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, '0, 5'd0, 5'd0, 5'd0, 32'h0002_0000,
              '0, 32'h0005_0000, '0, 1'b1);
      do_vtx("scale_xlate", {32'h0, 32'h0002_0000, 32'h0007_0000, 32'h0002_0000}, 1'b1, 1'b0);

      set_vtx(32'h7fff_0000, 32'h8001_0000, '0, '0, 5'd0, 5'd0, 5'd0, 32'h0002_0000, '0, '0, '0,
              1'b0);
      do_vtx("saturate", {32'h0, 32'h0, 32'h8000_0000, 32'h7fff_ffff}, 1'b0, 1'b0);

      // -1 LSB * 0.5 floors to -1; +1 LSB * 0.5 floors to 0
      set_vtx(32'hffff_ffff, 32'h0000_0001, '0, '0, 5'd0, 5'd0, 5'd0, 32'h0000_8000, '0, '0, '0,
              1'b0);
      do_vtx("floor", {32'h0, 32'h0, 32'h0, 32'hffff_ffff}, 1'b0, 1'b0);

      // Backpressure: hold 10 cycles, stray valid_in pulse ignored
      bus.ready_in = 1'b0;
      set_vtx(32'h0004_0000, 32'h0005_0000, 32'h0006_0000, 32'h0000_abcd, 5'd0, 5'd0, 5'd0,
              32'h0001_0000, '0, '0, '0, 1'b1);
      run_vtx(lat, 1'b0);
      check("bp latency", lat, 16);
      for (int i = 0; i < 10; i++) begin
         check("bp valid_out held", bus.valid_out, 1'b1);
         check("bp new_pos held", bus.new_pos, ExpA);
         check("bp obj_done_out held", bus.obj_done_out, 1'b1);
         check("bp ready_out low", bus.ready_out, 1'b0);
         if (i == 3) begin
            set_vtx(32'h0009_0000, 32'h0009_0000, 32'h0009_0000, 32'h0000_9999, 5'd8, 5'd8, 5'd8,
                    32'h0003_0000, '0, '0, '0, 1'b0);
            bus.valid_in = 1'b1;
         end
         if (i == 4) bus.valid_in = 1'b0;
         step();
      end
      set_vtx(32'h0007_0000, '0, '0, 32'h0000_bbbb, 5'd0, 5'd0, 5'd0, 32'h0001_0000, '0, '0, '0,
              1'b0);
      bus.valid_in = 1'b1;
      bus.ready_in = 1'b1;
      step();
      check("bp handshake valid_out", bus.valid_out, 1'b0);
      check("bp handshake ready_out", bus.ready_out, 1'b1);
      check("bp new_pos retained", bus.new_pos, ExpA);
      step();
      bus.valid_in = 1'b0;
      check("bp next accepted", bus.ready_out, 1'b0);
      wait_valid(lat);
      check("bp next latency", lat, 16);
      check("bp next new_pos", bus.new_pos, ExpB);
      check("bp next obj_done_out", bus.obj_done_out, 1'b0);
      step();

      // Async reset 7 cycles into compute, between clock edges
      set_vtx(32'h0005_0000, 32'h0005_0000, 32'h0005_0000, 32'h0000_1111, 5'd8, 5'd0, 5'd0,
              32'h0001_0000, '0, '0, '0, 1'b1);
      bus.valid_in = 1'b1;
      step();
      bus.valid_in = 1'b0;
      repeat (7) step();
      #3;
      rst_n = 1'b0;
      #1;
      check("async rst valid_out", bus.valid_out, 1'b0);
      check("async rst new_pos", bus.new_pos, '0);
      check("async rst ready_out", bus.ready_out, 1'b1);
      check("async rst obj_done_out", bus.obj_done_out, 1'b0);
      step();
      step();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (bus.valid_out === 1'b1) seen++;
      end
      check("aborted vertex not emitted", seen, 0);

      set_vtx(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0000_1234, 5'd0, 5'd0, 5'd0,
              32'h0001_0000, '0, '0, '0, 1'b1);
      do_vtx("post-reset identity", ExpIdent, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
